// File: rtl/serial_tx_scheduler_pkg.sv
`default_nettype none
//============================================================================
// Module      : serial_pkg
// Description : Shared constants and state encoding for the serial IP
//               transmit path. DATA_W, IDX_W and CNT_W are also used by the
//               transmit FIFO and the register file.
// Revision    : 1.0 - initial release
//============================================================================
package serial_pkg;

    localparam int DATA_W = 9;   // FIFO word width; bit 8 is carried untouched
    localparam int IDX_W  = 5;   // FIFO level / watermark width
    localparam int CNT_W  = 16;  // frame counter width

    // Transmit scheduler states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_POP     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_LOAD    = 3'd3,
        ST_SEND    = 3'd4,
        ST_DISCARD = 3'd5
    } tx_sched_state_t;

endpackage : serial_pkg
`default_nettype wire

// File: rtl/serial_tx_scheduler_if.sv
`default_nettype none
//============================================================================
// Module      : serial_tx_scheduler_if
// Description : FIFO read port and transmitter valid/ready handshake seen by
//               the transmit scheduler.
//   master : the scheduler (drives pop pulse and the tx word/valid)
//   slave  : the FIFO + UART transmitter side
// Revision    : 1.0 - initial release
//============================================================================
interface serial_tx_scheduler_if;
    import serial_pkg::*;

    // FIFO read side
    logic                 fifo_empty;
    logic [IDX_W-1:0]     fifo_watermark;
    logic [DATA_W-1:0]    fifo_rd_data;
    logic                 fifo_rd_request;

    // Transmitter side
    logic [DATA_W-1:0]    tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        input  fifo_empty,
        input  fifo_watermark,
        input  fifo_rd_data,
        output fifo_rd_request,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        output fifo_empty,
        output fifo_watermark,
        output fifo_rd_data,
        input  fifo_rd_request,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface : serial_tx_scheduler_if
`default_nettype wire

// File: rtl/serial_frame_counter.sv
`default_nettype none
//============================================================================
// Module      : serial_frame_counter
// Description : WIDTH-bit wrapping event counter with synchronous clear.
//               Clear has priority over increment. Shared by the transmit
//               and receive paths.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   inc   : count one event this cycle
//   clear : synchronous clear (wins over inc)
//   count : current count
// Revision    : 1.0 - initial release
//============================================================================
module serial_frame_counter
    import serial_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + c_one;   // natural wrap at all-ones
        end
    end

endmodule : serial_frame_counter
`default_nettype wire

// File: rtl/serial_tx_scheduler.sv
`default_nettype none
//============================================================================
// Module      : serial_tx_scheduler
// Description : Drains the transmit FIFO into the UART transmitter. Issues
//               single-cycle pop pulses, captures the popped word and offers
//               it on a valid/ready handshake; in flush mode popped words are
//               dropped. Also produces a registered low-watermark interrupt
//               and a count of completed handshakes.
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   enable       : scheduler enable
//   flush        : discard popped words instead of sending them
//   bus          : FIFO read port + transmitter handshake (master side)
//   irq_level    : low-watermark interrupt threshold
//   tx_irq       : level interrupt, enable & (fifo_watermark <= irq_level)
//   clear_count  : synchronous clear of frame_count
//   frame_count  : completed-handshake count, wraps
//   busy         : scheduler not in IDLE
// Revision    : 1.0 - initial release
//============================================================================
module serial_tx_scheduler
    import serial_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     flush,
    serial_tx_scheduler_if.master    bus,
    input  logic [IDX_W-1:0]         irq_level,
    output logic                     tx_irq,
    input  logic                     clear_count,
    output logic [CNT_W-1:0]         frame_count,
    output logic                     busy
);

    tx_sched_state_t     r_state;
    tx_sched_state_t     w_state_next;
    logic [DATA_W-1:0]   r_tx_data;
    logic                r_tx_irq;
    logic                w_handshake;

    //------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    //------------------------------------------------------------------
    // Next state and state-decoded outputs
    //------------------------------------------------------------------
    always_comb begin
        w_state_next        = r_state;
        bus.fifo_rd_request = 1'b0;
        bus.tx_valid        = 1'b0;
        w_handshake         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (enable && !bus.fifo_empty) begin
                    w_state_next = ST_POP;
                end
            end

            ST_POP: begin
                bus.fifo_rd_request = 1'b1;
                w_state_next        = ST_WAIT;
            end

            // flush is looked at only here, so a word already captured is
            // always completed regardless of later flush/enable changes.
            ST_WAIT: begin
                w_state_next = flush ? ST_DISCARD : ST_LOAD;
            end

            ST_LOAD: begin
                w_state_next = ST_SEND;
            end

            // The handshake cycle also makes the IDLE decision so a
            // continuously ready transmitter gets one word every 4 cycles.
            // POP, WAIT, LOAD and SEND still separate consecutive pop pulses
            // by 3 low cycles.
            ST_SEND: begin
                bus.tx_valid = 1'b1;
                if (bus.tx_ready) begin
                    w_handshake  = 1'b1;
                    w_state_next = (enable && !bus.fifo_empty) ? ST_POP : ST_IDLE;
                end
            end

            ST_DISCARD: begin
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Word capture: the FIFO read data is valid two cycles after the pop
    // pulse (edge-detect stage + registered read), i.e. during LOAD.
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data <= '0;
        end else if (r_state == ST_LOAD) begin
            r_tx_data <= bus.fifo_rd_data;
        end
    end

    //------------------------------------------------------------------
    // Low-watermark interrupt, one cycle behind the FIFO level
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_irq <= 1'b0;
        end else begin
            r_tx_irq <= enable & (bus.fifo_watermark <= irq_level);
        end
    end

    //------------------------------------------------------------------
    // Completed-frame counter
    //------------------------------------------------------------------
    serial_frame_counter #(
        .WIDTH (CNT_W)
    ) u_frame_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_handshake),
        .clear (clear_count),
        .count (frame_count)
    );

    assign bus.tx_data = r_tx_data;
    assign tx_irq      = r_tx_irq;
    assign busy        = (r_state != ST_IDLE);

endmodule : serial_tx_scheduler
`default_nettype wire

// File: tb/tb_serial_tx_scheduler.sv
`default_nettype none
//============================================================================
// Module      : tb_serial_tx_scheduler
// Description : Self-checking bench for serial_tx_scheduler. A small FIFO
//               model answers pop pulses (data two edges after the pulse);
//               expected values are hand-computed table entries.
// Revision    : 1.0 - initial release
//============================================================================
module tb_serial_tx_scheduler;
    import serial_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic               flush;
    logic               clear_count;
    logic               tx_irq;
    logic               busy;
    logic [IDX_W-1:0]   irq_level;
    logic [CNT_W-1:0]   frame_count;

    serial_tx_scheduler_if bus ();

    always #5 clk = ~clk;

    serial_tx_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .flush       (flush),
        .bus         (bus),
        .irq_level   (irq_level),
        .tx_irq      (tx_irq),
        .clear_count (clear_count),
        .frame_count (frame_count),
        .busy        (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    // FIFO model state
    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] pend;
    bit                pend_v    = 1'b0;
    bit                wm_manual = 1'b0;
    int                cycle     = 0;
    int                pops      = 0;
    int                last_pop  = -1;
    int                min_gap   = 1000;
    int                max_gap   = 0;

    typedef struct {
        logic [DATA_W-1:0] word;
        int                stall;
        bit                clr;
        logic [DATA_W-1:0] exp_data;
        logic [CNT_W-1:0]  exp_hold;
        logic [CNT_W-1:0]  exp_count;
    } tx_vec_t;

    typedef struct {
        logic [IDX_W-1:0] wm;
        logic [IDX_W-1:0] level;
        logic             en;
        logic             exp_irq;
    } irq_vec_t;

    tx_vec_t  txv[4];
    irq_vec_t irqv[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // One clock: sample the pop request before the edge, update the FIFO
    // model just after it, and return at the following falling edge.
    task automatic tick();
        logic req;
        int   gap;
        req = bus.fifo_rd_request;
        @(posedge clk);
        #1;
        cycle++;
        if (pend_v) begin
            bus.fifo_rd_data = pend;
            pend_v = 1'b0;
        end
        if (req) begin
            pops++;
            if (last_pop >= 0) begin
                gap = cycle - last_pop;
                if (gap < min_gap) min_gap = gap;
                if (gap > max_gap) max_gap = gap;
            end
            last_pop = cycle;
            if (fifo_q.size() > 0) begin
                pend   = fifo_q.pop_front();
                pend_v = 1'b1;
            end
        end
        bus.fifo_empty = (fifo_q.size() == 0);
        if (!wm_manual) bus.fifo_watermark = IDX_W'(fifo_q.size());
        @(negedge clk);
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        fifo_q.push_back(w);
        bus.fifo_empty = 1'b0;
        if (!wm_manual) bus.fifo_watermark = IDX_W'(fifo_q.size());
    endtask

    task automatic reset_gaps();
        last_pop = -1;
        min_gap  = 1000;
        max_gap  = 0;
    endtask

    // One word from an idle scheduler through a (possibly stalled) handshake.
    task automatic send_word(input tx_vec_t v);
        int lat;
        int p0;
        bit stable;
        p0           = pops;
        bus.tx_ready = (v.stall == 0);
        push(v.word);
        lat = 0;
        while (!bus.tx_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency_to_valid", 32'(lat), 32'd4);
        check("tx_data", 32'(bus.tx_data), 32'(v.exp_data));
        stable = 1'b1;
        for (int i = 0; i < v.stall; i++) begin
            tick();
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== v.exp_data ||
                frame_count !== v.exp_hold || pops != p0 + 1) stable = 1'b0;
        end
        check("stall_stable", 32'(stable), 32'd1);
        bus.tx_ready = 1'b1;
        clear_count  = v.clr;
        check("count_before_hs", 32'(frame_count), 32'(v.exp_hold));
        tick();
        clear_count  = 1'b0;
        bus.tx_ready = 1'b0;
        check("count_after_hs", 32'(frame_count), 32'(v.exp_count));
        check("valid_dropped", 32'(bus.tx_valid), 32'd0);
        check("single_pop", 32'(pops - p0), 32'd1);
        check("idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] got[$];
        bit                valid_seen;
        int                p0;
        tx_vec_t           wrapv;

        txv[0] = '{9'h1A5, 0,  1'b0, 9'h1A5, 16'd0, 16'd1};   // single word, bit 8 set
        txv[1] = '{9'h0FF, 10, 1'b0, 9'h0FF, 16'd1, 16'd2};   // 10-cycle backpressure
        txv[2] = '{9'h100, 3,  1'b0, 9'h100, 16'd2, 16'd3};   // only bit 8 set
        txv[3] = '{9'h000, 1,  1'b1, 9'h000, 16'd3, 16'd0};   // clear with handshake

        irqv[0] = '{5'd6,  5'd4,  1'b1, 1'b0};
        irqv[1] = '{5'd5,  5'd4,  1'b1, 1'b0};
        irqv[2] = '{5'd4,  5'd4,  1'b1, 1'b1};
        irqv[3] = '{5'd3,  5'd4,  1'b1, 1'b1};
        irqv[4] = '{5'd3,  5'd4,  1'b0, 1'b0};
        irqv[5] = '{5'd0,  5'd0,  1'b1, 1'b1};
        irqv[6] = '{5'd31, 5'd31, 1'b1, 1'b1};
        irqv[7] = '{5'd31, 5'd30, 1'b1, 1'b0};
        irqv[8] = '{5'd0,  5'd31, 1'b1, 1'b1};
        irqv[9] = '{5'd16, 5'd15, 1'b1, 1'b0};

        // ---------------- reset with a non-empty FIFO ----------------
        rst_n              = 1'b0;
        enable             = 1'b1;
        flush              = 1'b0;
        clear_count        = 1'b0;
        irq_level          = 5'd4;
        bus.tx_ready       = 1'b1;
        bus.fifo_empty     = 1'b0;
        bus.fifo_watermark = 5'd0;
        bus.fifo_rd_data   = 9'h1FF;
        repeat (3) @(negedge clk);
        check("rst_rd_request", 32'(bus.fifo_rd_request), 32'd0);
        check("rst_tx_valid",   32'(bus.tx_valid),        32'd0);
        check("rst_tx_data",    32'(bus.tx_data),         32'd0);
        check("rst_tx_irq",     32'(tx_irq),              32'd0);
        check("rst_frame_count",32'(frame_count),         32'd0);
        check("rst_busy",       32'(busy),                32'd0);

        // release with enable=0: nothing may be popped
        enable = 1'b0;
        rst_n  = 1'b1;
        push(9'h155);
        repeat (4) tick();
        check("disabled_no_pop",  32'(pops),   32'd0);
        check("disabled_idle",    32'(busy),   32'd0);
        check("disabled_no_irq",  32'(tx_irq), 32'd0);
        fifo_q.delete();
        bus.fifo_empty     = 1'b1;
        bus.fifo_watermark = 5'd0;
        tick();

        // ---------------- table-driven single transfers ----------------
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_word(txv[i]);
        end

        // ---------------- counter wrap ----------------
        force dut.u_frame_counter.count = 16'hFFFF;
        #1;
        release dut.u_frame_counter.count;
        tick();
        check("preload_held", 32'(frame_count), 32'h0000_FFFF);
        wrapv = '{9'h1C3, 0, 1'b0, 9'h1C3, 16'hFFFF, 16'h0000};
        send_word(wrapv);

        // ---------------- back-to-back throughput ----------------
        bus.tx_ready = 1'b1;
        reset_gaps();
        p0 = pops;
        push(9'h011);
        push(9'h022);
        push(9'h033);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.tx_valid) got.push_back(bus.tx_data);
        end
        check("tput_words", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            check("tput_word0", 32'(got[0]), 32'h011);
            check("tput_word1", 32'(got[1]), 32'h022);
            check("tput_word2", 32'(got[2]), 32'h033);
        end
        check("tput_pops",    32'(pops - p0),  32'd3);
        check("tput_min_gap", 32'(min_gap),    32'd4);
        check("tput_max_gap", 32'(max_gap),    32'd4);
        check("tput_count",   32'(frame_count),32'd3);
        bus.tx_ready = 1'b0;

        // ---------------- flush drain ----------------
        flush = 1'b1;
        reset_gaps();
        p0 = pops;
        valid_seen = 1'b0;
        for (int i = 0; i < 5; i++) push(DATA_W'(9'h100 + i));
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.tx_valid) valid_seen = 1'b1;
        end
        check("flush_pops",     32'(pops - p0),      32'd5);
        check("flush_min_gap",  32'(min_gap),        32'd4);
        check("flush_max_gap",  32'(max_gap),        32'd4);
        check("flush_no_valid", 32'(valid_seen),     32'd0);
        check("flush_count",    32'(frame_count),    32'd3);
        check("flush_idle",     32'(busy),           32'd0);
        check("flush_empty",    32'(bus.fifo_empty), 32'd1);
        flush = 1'b0;

        // ---------------- low-watermark interrupt ----------------
        wm_manual = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.fifo_watermark = irqv[i].wm;
            irq_level          = irqv[i].level;
            enable             = irqv[i].en;
            if (i > 0) check("irq_lag", 32'(tx_irq), 32'(irqv[i-1].exp_irq));
            tick();
            check("irq", 32'(tx_irq), 32'(irqv[i].exp_irq));
        end
        wm_manual          = 1'b0;
        bus.fifo_watermark = 5'd0;
        irq_level          = 5'd4;
        enable             = 1'b1;

        // ---------------- reset while in SEND ----------------
        bus.tx_ready = 1'b0;
        push(9'h0AA);
        repeat (4) tick();
        check("pre_reset_valid", 32'(bus.tx_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.tx_valid),    32'd0);
        check("async_rst_busy",  32'(busy),            32'd0);
        check("async_rst_data",  32'(bus.tx_data),     32'd0);
        check("async_rst_count", 32'(frame_count),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_serial_tx_scheduler
`default_nettype wire
